// File: rtl/time_offset_scheduler_if.sv
// Requester-side handshake bundle for the time offset scheduler: per-requester
// request/offset from the requesters, ack/nack pulses back from the scheduler.
interface time_offset_scheduler_if #(
  parameter int unsigned NUM_REQ = 2
) ();
  logic [NUM_REQ-1:0]    iv_req;
  logic [NUM_REQ*49-1:0] iv_req_offset;
  logic [NUM_REQ-1:0]    ov_ack;
  logic [NUM_REQ-1:0]    ov_nack;

  modport master (
    output iv_req,
    output iv_req_offset,
    input  ov_ack,
    input  ov_nack
  );

  modport slave (
    input  iv_req,
    input  iv_req_offset,
    output ov_ack,
    output ov_nack
  );
endinterface

// File: rtl/time_offset_scheduler.sv
// Round-robin arbiter feeding the single offset-write port of the global time sync block.
// Rejects offsets with an illegal 8ns-cycle field and enforces a guard gap between grants.
module time_offset_scheduler #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  time_offset_scheduler_if.slave req_if,
  output logic [48:0]            ov_time_offset,
  output logic                   o_time_offset_wr,
  output logic                   o_busy,
  output logic [15:0]            ov_wr_cnt
);

  localparam int unsigned OffW   = 49;
  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GuardW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGuard
  } state_e;

  state_e              r_state;
  logic [IdxW-1:0]     r_ptr;
  logic [IdxW-1:0]     r_idx;
  logic [OffW-1:0]     r_offset;
  logic [GuardW-1:0]   r_guard;
  logic [NUM_REQ-1:0]  r_ack;
  logic [NUM_REQ-1:0]  r_nack;
  logic                r_wr;
  logic [OffW-1:0]     r_time_offset;
  logic [15:0]         r_wr_cnt;

  logic [OffW-1:0]     w_offsets [NUM_REQ];
  logic                w_grant_vld;
  logic [IdxW-1:0]     w_grant_idx;
  logic [IdxW-1:0]     w_cand;
  logic                w_cyc_illegal;
  logic                w_mag_zero;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign w_offsets[k] = req_if.iv_req_offset[k*OffW +: OffW];
  end

  // Scan from the farthest candidate toward ptr+1 so the nearest set request wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int unsigned i = NUM_REQ; i >= 1; i--) begin
      w_cand = IdxW'((32'(r_ptr) + i) % NUM_REQ);
      if (req_if.iv_req[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  assign w_cyc_illegal = (r_offset[6:0] > 7'd124);
  assign w_mag_zero    = (r_offset[47:0] == 48'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_ptr         <= IdxW'(NUM_REQ - 1);
      r_idx         <= '0;
      r_offset      <= '0;
      r_guard       <= '0;
      r_ack         <= '0;
      r_nack        <= '0;
      r_wr          <= 1'b0;
      r_time_offset <= '0;
      r_wr_cnt      <= '0;
    end else begin
      r_ack  <= '0;
      r_nack <= '0;
      r_wr   <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_enable && w_grant_vld) begin
            r_idx    <= w_grant_idx;
            r_ptr    <= w_grant_idx;
            r_offset <= w_offsets[w_grant_idx];
            r_state  <= StIssue;
          end
        end
        StIssue: begin
          if (w_cyc_illegal) begin
            r_nack[r_idx] <= 1'b1;
          end else if (w_mag_zero) begin
            // Zero correction of either sign is acknowledged but never written.
            r_ack[r_idx] <= 1'b1;
          end else begin
            r_ack[r_idx]  <= 1'b1;
            r_wr          <= 1'b1;
            r_time_offset <= r_offset;
            r_wr_cnt      <= r_wr_cnt + 16'd1;
          end
          r_guard <= GuardW'(GUARD_CYCLES - 1);
          r_state <= StGuard;
        end
        StGuard: begin
          if (r_guard == '0) begin
            r_state <= StIdle;
          end else begin
            r_guard <= r_guard - GuardW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_if.ov_ack    = r_ack;
  assign req_if.ov_nack   = r_nack;
  assign ov_time_offset   = r_time_offset;
  assign o_time_offset_wr = r_wr;
  assign o_busy           = (r_state != StIdle);
  assign ov_wr_cnt        = r_wr_cnt;

endmodule
